multimode_ff_bank: RTL and testbench

MULTIMODE_FF_BANK -- requirements
Module: multimode_ff_bank

---
 rtl/multimode_ff_bank.sv | 105 ++++++++++
 tb/tb_multimode_ff_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH flip-flops sharing one storage mode (D, T, JK or SR), with
// per-bit synchronous preset/clear, a sticky illegal-SR flag and a
// saturating count of cycles in which the stored value changed.
module multimode_ff_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    input  logic [WIDTH-1:0] preset,
    input  logic [WIDTH-1:0] clr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sr_err,
    output logic [CNT_W-1:0] chg_cnt
);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } mode_t;

    mode_t            mode_e;
    logic [WIDTH-1:0] q_next;
    logic             sr_viol;
    logic             err_next;
    logic [CNT_W-1:0] cnt_next;

    assign mode_e = mode_t'(mode);

    // Per-bit next state: clr beats preset, both beat the enable, mode rule last.
    always_comb begin
        q_next = q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (clr[i]) begin
                q_next[i] = 1'b0;
            end else if (preset[i]) begin
                q_next[i] = 1'b1;
            end else if (en) begin
                case (mode_e)
                    MODE_D:  q_next[i] = a[i];
                    MODE_T:  q_next[i] = q[i] ^ a[i];
                    MODE_JK: begin
                        case ({a[i], b[i]})
                            2'b01:   q_next[i] = 1'b0;
                            2'b10:   q_next[i] = 1'b1;
                            2'b11:   q_next[i] = ~q[i];
                            default: q_next[i] = q[i];
                        endcase
                    end
                    MODE_SR: begin
                        case ({a[i], b[i]})
                            2'b01:   q_next[i] = 1'b0;
                            2'b10:   q_next[i] = 1'b1;
                            default: q_next[i] = q[i];
                        endcase
                    end
                    default: q_next[i] = q[i];
                endcase
            end
        end
    end

    // Illegal SR detection and sticky flag update; a new violation beats err_clr.
    always_comb begin
        sr_viol  = (mode_e == MODE_SR) && en && (|(a & b & ~clr & ~preset));
        err_next = sr_err;
        if (sr_viol) begin
            err_next = 1'b1;
        end else if (err_clr) begin
            err_next = 1'b0;
        end
    end

    // Change counter: count any edge where q moves, stop at all-ones.
    always_comb begin
        cnt_next = chg_cnt;
        if ((q_next != q) && (chg_cnt != '1)) begin
            cnt_next = chg_cnt + 1'b1;
        end
    end

    // State registers; qn is registered alongside q rather than derived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            qn      <= '1;
            sr_err  <= 1'b0;
            chg_cnt <= '0;
        end else begin
            q       <= q_next;
            qn      <= ~q_next;
            sr_err  <= err_next;
            chg_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_multimode_ff_bank.sv
module tb_multimode_ff_bank;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [7:0] a, b, preset, clr;
    logic       en, err_clr;
    logic [7:0] q, qn, q2, qn2;
    logic       sr_err, sr_err2;
    logic [7:0] chg_cnt;
    logic [1:0] chg_cnt2;

    int total = 0;
    int bad   = 0;

    multimode_ff_bank #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .a(a), .b(b), .en(en),
        .preset(preset), .clr(clr), .err_clr(err_clr),
        .q(q), .qn(qn), .sr_err(sr_err), .chg_cnt(chg_cnt)
    );

    multimode_ff_bank #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .a(a), .b(b), .en(en),
        .preset(preset), .clr(clr), .err_clr(err_clr),
        .q(q2), .qn(qn2), .sr_err(sr_err2), .chg_cnt(chg_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [7:0] m_q   = 8'h00;
    logic       m_err = 1'b0;
    int         m_cnt = 0;
    int         m_cnt2 = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] nq;
        logic       viol;
        if (!rst_n) begin
            m_q = 8'h00; m_err = 1'b0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            viol = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (clr[i])         nq[i] = 1'b0;
                else if (preset[i]) nq[i] = 1'b1;
                else if (!en)       nq[i] = m_q[i];
                else if (mode == 2'd0) nq[i] = a[i];
                else if (mode == 2'd1) nq[i] = a[i] ? !m_q[i] : m_q[i];
                else if (a[i] && b[i]) nq[i] = (mode == 2'd2) ? !m_q[i] : m_q[i];
                else if (a[i])      nq[i] = 1'b1;
                else if (b[i])      nq[i] = 1'b0;
                else                nq[i] = m_q[i];
                if (mode == 2'd3 && en && a[i] && b[i] && !clr[i] && !preset[i])
                    viol = 1'b1;
            end
            if (viol)         m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (nq != m_q) begin
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                if (m_cnt2 < 3)  m_cnt2 = m_cnt2 + 1;
            end
            m_q = nq;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("cyc_q",    {24'd0, q},        {24'd0, m_q});
        check("cyc_qn",   {24'd0, qn},       {24'd0, ~m_q});
        check("cyc_err",  {31'd0, sr_err},   {31'd0, m_err});
        check("cyc_cnt",  {24'd0, chg_cnt},  m_cnt);
        check("cyc_q2",   {24'd0, q2},       {24'd0, m_q});
        check("cyc_cnt2", {30'd0, chg_cnt2}, m_cnt2);
    end

    task automatic apply(input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv,
                         input logic e, input logic [7:0] p, input logic [7:0] c,
                         input logic ec);
        mode = m; a = av; b = bv; en = e; preset = p; clr = c; err_clr = ec;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_q",    {24'd0, q},        32'h00);
        check("rst_qn",   {24'd0, qn},       32'hFF);
        check("rst_err",  {31'd0, sr_err},   32'h0);
        check("rst_cnt",  {24'd0, chg_cnt},  32'h0);
        check("rst_cnt2", {30'd0, chg_cnt2}, 32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        mode = 2'd0; a = '0; b = '0; en = 1'b0; preset = '0; clr = '0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("init_q",   {24'd0, q},       32'h00);
        check("init_qn",  {24'd0, qn},      32'hFF);
        check("init_err", {31'd0, sr_err},  32'h0);
        check("init_cnt", {24'd0, chg_cnt}, 32'h0);
        #1;
        rst_n = 1'b1;

        // D load
        apply(2'd0, 8'hA5, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0);
        check("d_q",   {24'd0, q},       32'hA5);
        check("d_qn",  {24'd0, qn},      32'h5A);
        check("d_cnt", {24'd0, chg_cnt}, 32'h1);
        // en=0 holds
        apply(2'd0, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        check("hold_q", {24'd0, q}, 32'hA5);

        // T toggling from zero, and CNT_W=2 saturation
        reset_pulse();
        apply(2'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0);
        check("t1_q", {24'd0, q}, 32'hFF);
        apply(2'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0);
        check("t2_q", {24'd0, q}, 32'h00);
        apply(2'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0);
        check("t3_q",   {24'd0, q},       32'hFF);
        check("t3_cnt", {24'd0, chg_cnt}, 32'h3);
        apply(2'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0);
        apply(2'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0);
        check("t5_cnt",  {24'd0, chg_cnt},  32'h5);
        check("t5_cnt2", {30'd0, chg_cnt2}, 32'h3);

        // JK
        apply(2'd0, 8'h0F, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0);
        apply(2'd2, 8'hF0, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0);
        check("jk_q", {24'd0, q}, 32'hF0);

        // SR and the sticky error flag
        apply(2'd0, 8'h01, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0);
        apply(2'd3, 8'h01, 8'h01, 1'b1, 8'h00, 8'h00, 1'b0);
        check("sr_q",   {24'd0, q},      32'h01);
        check("sr_err", {31'd0, sr_err}, 32'h1);
        apply(2'd3, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1);
        check("sr_clr_err", {31'd0, sr_err}, 32'h0);
        check("sr_clr_q",   {24'd0, q},      32'h01);
        apply(2'd3, 8'h01, 8'h01, 1'b1, 8'h00, 8'h00, 1'b1);
        check("sr_setwins", {31'd0, sr_err}, 32'h1);

        // preset/clr override en=0; clr beats preset
        apply(2'd0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1);
        apply(2'd0, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h0F, 1'b0);
        check("pc_q", {24'd0, q}, 32'hF0);

        // Mixed vectors covered by the per-cycle compare
        for (int k = 0; k < 60; k++) begin
            apply(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                  ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset mid-operation
        apply(2'd0, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0);
        reset_pulse();
        apply(2'd0, 8'h3C, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0);
        check("post_rst_q",   {24'd0, q},       32'h3C);
        check("post_rst_cnt", {24'd0, chg_cnt}, 32'h1);
        apply(2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
